// File: rtl/rs_checker.sv
`default_nettype none
// ============================================================================
// Module   : rs_checker
// Purpose  : Response checker for the clocked RS flip-flop. It models the
//            flip-flop, flags wrong q/qb and forbidden s=r=1, and keeps
//            saturating error and comparison counters.
//            Optional macro RS_CHK_FORBID_ERR_EN: forbidden inputs also count
//            as errors.
// Revision : 1.0 - initial release
// ============================================================================
module rs_checker #(
    parameter int CNT_W     = 8,
    parameter int ERR_LIMIT = 1
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             en,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             qb,
    output logic             exp_q,
    output logic             valid,
    output logic             mismatch,
    output logic             forbid,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic             fail
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_UNK   = 2'd1,
        ST_KNOWN = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_ERR_LIMIT = CNT_W'(ERR_LIMIT);

    state_e           state_q, state_d;
    logic             exp_q_q, exp_q_d;
    logic             valid_q, valid_d;
    logic             mismatch_q, mismatch_d;
    logic             forbid_q, forbid_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
    logic             fail_q, fail_d;

    logic             w_set;
    logic             w_clr;
    logic             w_forb;
    logic             w_bad;
    logic [1:0]       w_err_inc;
    logic [CNT_W:0]   w_err_sum;

    assign w_set  = s & ~r;
    assign w_clr  = ~s & r;
    assign w_forb = s & r;
    // q/qb seen now belong to the s/r sampled one edge ago, i.e. to exp_q_q.
    assign w_bad  = (q != exp_q_q) | (qb != ~exp_q_q);

    always_comb begin
        state_d    = state_q;
        exp_q_d    = exp_q_q;
        mismatch_d = 1'b0;
        forbid_d   = 1'b0;
        chk_cnt_d  = chk_cnt_q;
        w_err_inc  = 2'd0;

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_UNK;
                end
                ST_UNK: begin
                    if (w_forb) begin
                        forbid_d = 1'b1;
`ifdef RS_CHK_FORBID_ERR_EN
                        w_err_inc = w_err_inc + 2'd1;
`endif
                    end else if (w_set) begin
                        state_d = ST_KNOWN;
                        exp_q_d = 1'b1;
                    end else if (w_clr) begin
                        state_d = ST_KNOWN;
                        exp_q_d = 1'b0;
                    end
                end
                ST_KNOWN: begin
                    if (chk_cnt_q != c_CNT_MAX) begin
                        chk_cnt_d = chk_cnt_q + c_CNT_ONE;
                    end
                    if (w_bad) begin
                        mismatch_d = 1'b1;
                        w_err_inc  = w_err_inc + 2'd1;
                    end
                    if (w_forb) begin
                        forbid_d = 1'b1;
                        state_d  = ST_UNK;
`ifdef RS_CHK_FORBID_ERR_EN
                        w_err_inc = w_err_inc + 2'd1;
`endif
                    end else if (w_set) begin
                        exp_q_d = 1'b1;
                    end else if (w_clr) begin
                        exp_q_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        valid_d = (state_d == ST_KNOWN);

        // One bit of headroom lets a double increment clamp instead of wrap.
        w_err_sum = {1'b0, err_cnt_q} + (CNT_W+1)'(w_err_inc);
        if (w_err_sum > {1'b0, c_CNT_MAX}) begin
            err_cnt_d = c_CNT_MAX;
        end else begin
            err_cnt_d = w_err_sum[CNT_W-1:0];
        end

        fail_d = fail_q | (err_cnt_d >= c_ERR_LIMIT);
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            exp_q_q    <= 1'b0;
            valid_q    <= 1'b0;
            mismatch_q <= 1'b0;
            forbid_q   <= 1'b0;
            err_cnt_q  <= '0;
            chk_cnt_q  <= '0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q_q    <= exp_q_d;
            valid_q    <= valid_d;
            mismatch_q <= mismatch_d;
            forbid_q   <= forbid_d;
            err_cnt_q  <= err_cnt_d;
            chk_cnt_q  <= chk_cnt_d;
            fail_q     <= fail_d;
        end
    end

    assign exp_q    = exp_q_q;
    assign valid    = valid_q;
    assign mismatch = mismatch_q;
    assign forbid   = forbid_q;
    assign err_cnt  = err_cnt_q;
    assign chk_cnt  = chk_cnt_q;
    assign fail     = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_checker
// Purpose  : Self-checking bench for rs_checker; two instances (default and
//            CNT_W=2/ERR_LIMIT=3) share stimulus and are scored per edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_checker;

    logic CLOCK_50 = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic s = 1'b0;
    logic r = 1'b0;
    logic q = 1'b0;
    logic qb = 1'b1;

    logic       exp_q0, valid0, mismatch0, forbid0, fail0;
    logic [7:0] err_cnt0, chk_cnt0;
    logic       exp_q1, valid1, mismatch1, forbid1, fail1;
    logic [1:0] err_cnt1, chk_cnt1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic       exp_q;
        logic       valid;
        logic       mismatch;
        logic       forbid;
        logic [7:0] err;
        logic [7:0] chk;
        logic       fail;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    // Reference model state, index 0 = default instance, 1 = small instance.
    int   m_state [2];
    logic m_exp   [2];
    int   m_err   [2];
    int   m_chk   [2];
    logic m_fail  [2];
    logic ff;

    always #5 CLOCK_50 = ~CLOCK_50;

    rs_checker u_dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .en       (en),
        .s        (s),
        .r        (r),
        .q        (q),
        .qb       (qb),
        .exp_q    (exp_q0),
        .valid    (valid0),
        .mismatch (mismatch0),
        .forbid   (forbid0),
        .err_cnt  (err_cnt0),
        .chk_cnt  (chk_cnt0),
        .fail     (fail0)
    );

    rs_checker #(.CNT_W(2), .ERR_LIMIT(3)) u_sat (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .en       (en),
        .s        (s),
        .r        (r),
        .q        (q),
        .qb       (qb),
        .exp_q    (exp_q1),
        .valid    (valid1),
        .mismatch (mismatch1),
        .forbid   (forbid1),
        .err_cnt  (err_cnt1),
        .chk_cnt  (chk_cnt1),
        .fail     (fail1)
    );

    task automatic model(input int i, input logic mr, me, ms, mrr, mq, mqb,
                         output exp_t e);
        int inc;
        int mx;
        int lim;
        mx  = (i == 0) ? 255 : 3;
        lim = (i == 0) ? 1 : 3;
        inc = 0;
        e   = '0;
        if (mr) begin
            m_state[i] = 0;
            m_exp[i]   = 1'b0;
            m_err[i]   = 0;
            m_chk[i]   = 0;
            m_fail[i]  = 1'b0;
        end else if (!me) begin
            m_state[i] = 0;
        end else begin
            case (m_state[i])
                0: m_state[i] = 1;
                1: begin
                    if (ms && mrr) begin
                        e.forbid = 1'b1;
`ifdef RS_CHK_FORBID_ERR_EN
                        inc++;
`endif
                    end else if (ms) begin
                        m_state[i] = 2; m_exp[i] = 1'b1;
                    end else if (mrr) begin
                        m_state[i] = 2; m_exp[i] = 1'b0;
                    end
                end
                default: begin
                    if (m_chk[i] < mx) m_chk[i]++;
                    if (mq !== m_exp[i] || mqb !== ~m_exp[i]) begin
                        e.mismatch = 1'b1;
                        inc++;
                    end
                    if (ms && mrr) begin
                        e.forbid   = 1'b1;
                        m_state[i] = 1;
`ifdef RS_CHK_FORBID_ERR_EN
                        inc++;
`endif
                    end else if (ms) begin
                        m_exp[i] = 1'b1;
                    end else if (mrr) begin
                        m_exp[i] = 1'b0;
                    end
                end
            endcase
            m_err[i] = (m_err[i] + inc > mx) ? mx : m_err[i] + inc;
            if (m_err[i] >= lim) m_fail[i] = 1'b1;
        end
        e.exp_q = m_exp[i];
        e.valid = (m_state[i] == 2);
        e.err   = 8'(m_err[i]);
        e.chk   = 8'(m_chk[i]);
        e.fail  = m_fail[i];
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s c%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic compare_all();
        exp_t e;
        if (sb0.size() == 0 || sb1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty c%0d observed=0 expected=1", cyc);
            return;
        end
        e = sb0.pop_front();
        chk("exp_q0",    {7'd0, exp_q0},    {7'd0, e.exp_q});
        chk("valid0",    {7'd0, valid0},    {7'd0, e.valid});
        chk("mismatch0", {7'd0, mismatch0}, {7'd0, e.mismatch});
        chk("forbid0",   {7'd0, forbid0},   {7'd0, e.forbid});
        chk("err_cnt0",  err_cnt0,          e.err);
        chk("chk_cnt0",  chk_cnt0,          e.chk);
        chk("fail0",     {7'd0, fail0},     {7'd0, e.fail});
        e = sb1.pop_front();
        chk("exp_q1",    {7'd0, exp_q1},    {7'd0, e.exp_q});
        chk("valid1",    {7'd0, valid1},    {7'd0, e.valid});
        chk("mismatch1", {7'd0, mismatch1}, {7'd0, e.mismatch});
        chk("forbid1",   {7'd0, forbid1},   {7'd0, e.forbid});
        chk("err_cnt1",  {6'd0, err_cnt1},  e.err);
        chk("chk_cnt1",  {6'd0, chk_cnt1},  e.chk);
        chk("fail1",     {7'd0, fail1},     {7'd0, e.fail});
    endtask

    // Drive one edge worth of inputs, predict, then score just after the edge.
    task automatic step(input logic i_rst, i_en, i_s, i_r, i_q, i_qb);
        exp_t e;
        rst = i_rst; en = i_en; s = i_s; r = i_r; q = i_q; qb = i_qb;
        model(0, i_rst, i_en, i_s, i_r, i_q, i_qb, e);
        sb0.push_back(e);
        model(1, i_rst, i_en, i_s, i_r, i_q, i_qb, e);
        sb1.push_back(e);
        @(posedge CLOCK_50);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic ff_update(input logic i_s, i_r);
        if (i_s && !i_r) ff = 1'b1;
        else if (!i_s && i_r) ff = 1'b0;
    endtask

    task automatic good(input logic i_s, i_r);
        step(1'b0, 1'b1, i_s, i_r, ff, ~ff);
        ff_update(i_s, i_r);
    endtask

    task automatic fault(input logic i_s, i_r);
        step(1'b0, 1'b1, i_s, i_r, ~ff, ff);
        ff_update(i_s, i_r);
    endtask

    initial begin
        ff = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_exp[i] = 1'b0; m_err[i] = 0;
            m_chk[i] = 0; m_fail[i] = 1'b0;
        end
        #2;

        // Reset then idle
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        // Correct flip-flop sequence
        good(1'b0, 1'b0);
        good(1'b0, 1'b1);
        good(1'b0, 1'b0);
        good(1'b1, 1'b0);
        good(1'b0, 1'b0);
        good(1'b0, 1'b1);

        // Injected fault with exp_q=1
        good(1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        good(1'b0, 1'b0);
        good(1'b0, 1'b0);

        // Forbidden input, then recovery through UNK
        good(1'b1, 1'b1);
        good(1'b0, 1'b0);
        good(1'b1, 1'b0);
        good(1'b0, 1'b0);
        good(1'b1, 1'b1);
        good(1'b1, 1'b1);
        good(1'b0, 1'b1);
        good(1'b0, 1'b0);

        // Saturation on the small instance
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        good(1'b0, 1'b0);
        good(1'b1, 1'b0);
        repeat (6) fault(1'b0, 1'b0);
        good(1'b0, 1'b0);

        // Disable and reset mid-run
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        good(1'b0, 1'b0);
        good(1'b0, 1'b1);
        fault(1'b0, 1'b0);
        fault(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, ff, ~ff);
        good(1'b0, 1'b0);
        good(1'b1, 1'b0);
        fault(1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, ~ff, ff);
        good(1'b0, 1'b0);

        // Mixed traffic
        for (int k = 0; k < 300; k++) begin
            logic ls, lr, le, lf;
            ls = 1'($urandom_range(0, 1));
            lr = (ls && $urandom_range(0, 5) != 0) ? 1'b0 : 1'($urandom_range(0, 1));
            le = ($urandom_range(0, 9) != 0);
            lf = ($urandom_range(0, 7) == 0);
            step(1'b0, le, ls, lr, ff ^ lf, ~ff);
            ff_update(ls, lr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rs_checker.md
Name: rs_checker

Overview:
- Synthesizable response checker for the clocked RS flip-flop `rs`.
- Sits beside the flip-flop on the same CLOCK_50. It samples the s/r stimulus and the q/qb response.
- Holds a reference model of the flip-flop, flags wrong outputs and forbidden inputs, and counts errors.
- Lets the flip-flop be checked on the board or in any bench without a waveform inspection.

Parameters:
- CNT_W, 8: width of err_cnt and chk_cnt. Both saturate at all-ones.
- ERR_LIMIT, 1: fail asserts once err_cnt >= ERR_LIMIT. Legal range 1 .. 2^CNT_W-1.

Ports:
- CLOCK_50, input, 1: the single clock; all logic on posedge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: checking enable.
- s, input, 1: set input driven to the flip-flop.
- r, input, 1: reset input driven to the flip-flop.
- q, input, 1: flip-flop output.
- qb, input, 1: flip-flop complementary output.
- exp_q, output, 1: model's expected q.
- valid, output, 1: model state is known; exp_q is meaningful.
- mismatch, output, 1: one-cycle pulse, q/qb wrong.
- forbid, output, 1: one-cycle pulse, s=r=1 was sampled while enabled.
- err_cnt, output, CNT_W: saturating error count.
- chk_cnt, output, CNT_W: saturating count of performed comparisons.
- fail, output, 1: sticky failure flag.

Behaviour:
- Interface: one clock, CLOCK_50. rst is synchronous and active-high; it acts on the posedge where rst=1.
- Reset values: state=IDLE, exp_q=0, valid=0, mismatch=0, forbid=0, err_cnt=0, chk_cnt=0, fail=0.
- Reset mid-operation clears everything at that edge, including a pending mismatch or forbid pulse.
- Flip-flop model, sampled at posedge:
  - s=1, r=0: set, q=1.
  - s=0, r=1: clear, q=0.
  - s=0, r=0: hold.
  - s=1, r=1: forbidden; q becomes unknown.
- DUT timing: q/qb reflect the s/r sampled at edge N from after edge N. The checker compares q/qb at edge N+1 against exp_q as registered at edge N.
- FSM, state IDLE:
  - en=1 -> UNK.
  - Nothing is sampled or compared; valid=0.
- FSM, state UNK (model unknown, valid=0, no compare, chk_cnt unchanged):
  - Set -> KNOWN, exp_q=1.
  - Clear -> KNOWN, exp_q=0.
  - Hold -> stay in UNK.
  - Forbidden -> stay in UNK and pulse forbid.
- FSM, state KNOWN (valid=1):
  - Every edge: chk_cnt += 1.
  - Compare q==exp_q and qb==~exp_q. If either fails, pulse mismatch and err_cnt += 1.
  - Then apply the sampled s/r to exp_q.
  - Forbidden s/r -> pulse forbid, go to UNK; exp_q holds its last value, valid=0.
- Any state, en=0 at an edge -> IDLE.
  - Counters, fail and exp_q hold their values; valid=0; pulses are 0.
  - Re-enabling enters UNK; the flip-flop's state is not trusted across a disable.
- Pulse timing: mismatch and forbid are registered. They are high for exactly the cycle following the edge that detected them.
- Counters saturate at 2^CNT_W-1; they never wrap.
- When two increments of err_cnt occur in one edge, the count adds 2 and clamps at the saturation value. This case arises only with the optional feature enabled.
- fail is registered and rises on the edge where err_cnt reaches ERR_LIMIT. Only rst clears it.
- Combinational path inputs -> outputs: none. All outputs are registers.

Optional Feature:
- Macro: RS_CHK_FORBID_ERR_EN.
- Defined: a forbidden s=r=1 sampled in UNK or KNOWN also increments err_cnt. It can therefore raise fail.
- Defined, KNOWN state: a mismatch and a forbid on the same edge add 2 to err_cnt (saturating).
- Undefined: forbid only pulses forbid and forces UNK; err_cnt is unaffected.

Test Plan:
1. Reset and idle. Hold rst=1 for 2 edges, then en=0 for 3 edges. Expected: all outputs 0, IDLE throughout.
2. Correct flip-flop sequence. en=1, drive (s,r) = (0,1), (0,0), (1,0), (0,0), (0,1) on successive edges.
   - valid rises one edge after (0,1).
   - exp_q follows 0, 0, 1, 1, 0.
   - mismatch stays 0, chk_cnt=4, err_cnt=0, fail=0.
3. Injected fault. Flip-flop in KNOWN with exp_q=1, force q=0 and qb=1 for one edge.
   - mismatch pulses once; err_cnt=1; fail=1 on the same edge (ERR_LIMIT=1).
   - Remove the fault: mismatch=0, fail stays 1.
4. Forbidden input. In KNOWN, drive (1,1).
   - forbid pulses, valid=0, err_cnt unchanged without the macro.
   - The next (0,0) keeps UNK; the next (1,0) returns to KNOWN with exp_q=1.
   - Repeat with RS_CHK_FORBID_ERR_EN defined: err_cnt=1, fail=1.
5. Saturation. CNT_W=2, ERR_LIMIT=3, persistent q/qb fault for 6 KNOWN edges. Expected: err_cnt 1, 2, 3, 3, 3, 3; fail rises on the third edge.
6. Disable and reset mid-run.
   - With err_cnt=2, drop en for one edge: state IDLE, err_cnt stays 2.
   - Re-enable: UNK.
   - Assert rst during a fault: err_cnt=0, fail=0, mismatch=0 at that edge.
